i2c_frame_sequencer: RTL and testbench



---
 rtl/i2c_an_pkg.sv | 14 +
 rtl/i2c_frame_sequencer_if.sv | 36 +++
 rtl/i2c_line_sync.sv | 48 ++++
 rtl/i2c_frame_sequencer.sv | 139 +++++++++++++
 tb/tb_i2c_frame_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_an_pkg.sv
// Shared types and constants for the I2C frame sequencer.
package i2c_an_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_HOLD
  } state_t;

  localparam int   I2C_BITS_PER_FRAME = 9;
  localparam logic I2C_ACK            = 1'b0;

endpackage

// File: rtl/i2c_frame_sequencer_if.sv
// Bus pins and decoded event bundle of the I2C frame sequencer.
interface i2c_frame_sequencer_if #(
  parameter int FRAME_CNT_W = 16
);

  logic                   scl;
  logic                   sda;
  logic                   start_det;
  logic                   rstart_det;
  logic                   stop_det;
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   byte_is_addr;
  logic                   byte_ack;
  logic                   rw;
  logic                   busy;
  logic                   frame_err;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport slave (
    input  scl, sda,
    output start_det, rstart_det, stop_det,
    output byte_valid, byte_data, byte_is_addr,
    output byte_ack, rw, busy, frame_err,
    output frame_cnt
  );

  modport master (
    output scl, sda,
    input  start_det, rstart_det, stop_det,
    input  byte_valid, byte_data, byte_is_addr,
    input  byte_ack, rw, busy, frame_err,
    input  frame_cnt
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Per-line synchroniser, idles high; optional 3-sample agreement
// filter when I2C_GLITCH_FILTER_EN is defined.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic s;
  logic h1;
  logic h2;
  logic held;

  assign s = chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      h1   <= 1'b1;
      h2   <= 1'b1;
      held <= 1'b1;
    end else begin
      h1   <= s;
      h2   <= h1;
      held <= q;
    end
  end

  // Follow the line only once three consecutive samples agree
  assign q = (s == h1 && h1 == h2) ? s : held;
`else
  assign q = chain[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/i2c_frame_sequencer.sv
// I2C transaction decoder: START/STOP detection, byte framing, tagging.
// Optional glitch filter: define I2C_GLITCH_FILTER_EN.
module i2c_frame_sequencer
  import i2c_an_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_frame_sequencer_if.slave  bus
);

  localparam logic [3:0] LAST_BIT = 4'(I2C_BITS_PER_FRAME - 1);

  logic scl_s, sda_s;
  logic scl_p, sda_p;
  logic start_e, stop_e, rise_e, sda_e;

  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   partial;

  logic                   start_det, rstart_det, stop_det;
  logic                   byte_valid, byte_is_addr, byte_ack;
  logic [7:0]             byte_data;
  logic                   rw, busy, frame_err;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk   (clk),
    .reset (reset),
    .d     (bus.scl),
    .q     (scl_s)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sda),
    .q     (sda_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_p   <= 1'b1;
      sda_p   <= 1'b1;
      start_e <= 1'b0;
      stop_e  <= 1'b0;
      rise_e  <= 1'b0;
      sda_e   <= 1'b0;
    end else begin
      scl_p   <= scl_s;
      sda_p   <= sda_s;
      start_e <= scl_p & scl_s & sda_p & ~sda_s;
      stop_e  <= scl_p & scl_s & ~sda_p & sda_s;
      rise_e  <= ~scl_p & scl_s;
      sda_e   <= sda_s;
    end
  end

  assign partial = (bit_cnt != 4'd0) && (state != ST_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= 4'd0;
      shreg        <= 8'd0;
      start_det    <= 1'b0;
      rstart_det   <= 1'b0;
      stop_det     <= 1'b0;
      byte_valid   <= 1'b0;
      byte_data    <= 8'd0;
      byte_is_addr <= 1'b0;
      byte_ack     <= 1'b0;
      rw           <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (1'b1)
        start_e: begin
          start_det  <= (state == ST_IDLE);
          rstart_det <= (state != ST_IDLE);
          frame_err  <= partial;
          state      <= ST_ADDR;
          bit_cnt    <= 4'd0;
          busy       <= 1'b1;
        end
        stop_e: begin
          stop_det  <= 1'b1;
          frame_err <= partial;
          if (state != ST_IDLE && !partial)
            frame_cnt <= frame_cnt + 1'b1;
          state     <= ST_IDLE;
          bit_cnt   <= 4'd0;
          busy      <= 1'b0;
        end
        rise_e: begin
          if (state == ST_ADDR || state == ST_DATA) begin
            if (bit_cnt == LAST_BIT) begin
              byte_valid   <= 1'b1;
              byte_data    <= shreg;
              byte_is_addr <= (state == ST_ADDR);
              byte_ack     <= sda_e;
              if (state == ST_ADDR)
                rw <= shreg[0];
              bit_cnt <= 4'd0;
              state   <= (sda_e == I2C_ACK) ? ST_DATA : ST_HOLD;
            end else begin
              shreg   <= {shreg[6:0], sda_e};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_det    = start_det;
  assign bus.rstart_det   = rstart_det;
  assign bus.stop_det     = stop_det;
  assign bus.byte_valid   = byte_valid;
  assign bus.byte_data    = byte_data;
  assign bus.byte_is_addr = byte_is_addr;
  assign bus.byte_ack     = byte_ack;
  assign bus.rw           = rw;
  assign bus.busy         = busy;
  assign bus.frame_err    = frame_err;
  assign bus.frame_cnt    = frame_cnt;

endmodule

// File: tb/tb_i2c_frame_sequencer.sv
// Scoreboard bench for i2c_frame_sequencer (directed I2C sequences).
// Honours I2C_GLITCH_FILTER_EN for latency and glitch cases.
module tb_i2c_frame_sequencer;

  localparam int CW = 8;
`ifdef I2C_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  typedef struct packed {
    logic          st;
    logic          rs;
    logic          sp;
    logic          bv;
    logic          fe;
    logic          busy;
    logic [7:0]    data;
    logic          isa;
    logic          ack;
    logic          rw;
    logic [CW-1:0] cnt;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_start_cyc = -1;

  ev_t  exp_q[$];

  logic          m_busy = 1'b0;
  logic          m_rw = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  i2c_frame_sequencer_if #(.FRAME_CNT_W(CW)) bus ();

  i2c_frame_sequencer #(
    .SYNC_STAGES (2),
    .FRAME_CNT_W (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every pulse-carrying cycle is one observed event
  always @(negedge clk) begin
    ev_t o;
    ev_t e;
    if (bus.start_det | bus.rstart_det | bus.stop_det |
        bus.byte_valid | bus.frame_err) begin
      o      = '0;
      o.st   = bus.start_det;
      o.rs   = bus.rstart_det;
      o.sp   = bus.stop_det;
      o.bv   = bus.byte_valid;
      o.fe   = bus.frame_err;
      o.busy = bus.busy;
      o.rw   = bus.rw;
      o.cnt  = bus.frame_cnt;
      if (bus.byte_valid) begin
        o.data = bus.byte_data;
        o.isa  = bus.byte_is_addr;
        o.ack  = bus.byte_ack;
      end
      if (bus.start_det)
        last_start_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%h exp=none at cyc %0d",
                 o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL event got=%h exp=%h at cyc %0d", o, e, cyc);
        end
      end
    end
  end

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic wc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ex_start();
    ev_t e = '0;
    e.st   = !m_busy;
    e.rs   = m_busy;
    m_busy = 1'b1;
    e.busy = 1'b1;
    e.rw   = m_rw;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic ex_byte(logic [7:0] d, logic isa, logic ack);
    ev_t e = '0;
    if (isa) m_rw = d[0];
    e.bv   = 1'b1;
    e.data = d;
    e.isa  = isa;
    e.ack  = ack;
    e.busy = 1'b1;
    e.rw   = m_rw;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic ex_stop(logic err);
    ev_t e = '0;
    if (m_busy && !err) m_cnt = m_cnt + 1'b1;
    m_busy = 1'b0;
    e.sp   = 1'b1;
    e.fe   = err;
    e.rw   = m_rw;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    if (!bus.scl) begin
      bus.sda = 1'b1; wc(4);
      bus.scl = 1'b1; wc(4);
    end
    bus.sda = 1'b0; wc(4);
    bus.scl = 1'b0; wc(4);
  endtask

  task automatic send_bit(logic b, logic keep_high);
    bus.sda = b;    wc(4);
    bus.scl = 1'b1; wc(4);
    if (!keep_high) begin
      bus.scl = 1'b0; wc(4);
    end
  endtask

  task automatic send_byte(logic [7:0] d, logic ack, logic keep_high);
    for (int i = 7; i >= 0; i--)
      send_bit(d[i], 1'b0);
    send_bit(ack, keep_high);
  endtask

  task automatic do_stop();
    if (!bus.scl) begin
      bus.sda = 1'b0; wc(4);
      bus.scl = 1'b1; wc(4);
    end
    bus.sda = 1'b1; wc(4);
  endtask

  initial begin
    int n0;
    bus.scl = 1'b1;
    bus.sda = 1'b1;
    wc(3);
    chk("reset_flags",
        {bus.start_det, bus.rstart_det, bus.stop_det, bus.byte_valid,
         bus.frame_err, bus.busy, bus.rw, bus.byte_is_addr, bus.byte_ack},
        32'h0);
    chk("reset_byte_data", bus.byte_data, 32'h0);
    chk("reset_frame_cnt", bus.frame_cnt, 32'h0);
    reset = 1'b0;
    wc(6);

    // Write A0 / 5A, STOP straight after the ACK clock
    n0 = cyc + 1;
    ex_start();
    do_start();
    ex_byte(8'hA0, 1'b1, 1'b0);
    send_byte(8'hA0, 1'b0, 1'b0);
    ex_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b1);
    ex_stop(1'b0);
    do_stop();
    wc(8);
    chk("start_latency", last_start_cyc - n0, LAT);
    chk("cnt_after_t1", bus.frame_cnt, 32'h1);
    chk("idle_after_t1", bus.busy, 32'h0);

    // Read A1, data 33 NACK, clocks in HOLD, STOP
    ex_start();
    do_start();
    ex_byte(8'hA1, 1'b1, 1'b0);
    send_byte(8'hA1, 1'b0, 1'b0);
    ex_byte(8'h33, 1'b0, 1'b1);
    send_byte(8'h33, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    ex_stop(1'b0);
    do_stop();
    wc(8);
    chk("rw_after_t2", bus.rw, 32'h1);
    chk("cnt_after_t2", bus.frame_cnt, 32'h2);

    // Repeated START from HOLD, new address byte
    ex_start();
    do_start();
    ex_byte(8'hA0, 1'b1, 1'b0);
    send_byte(8'hA0, 1'b0, 1'b0);
    ex_byte(8'h10, 1'b0, 1'b1);
    send_byte(8'h10, 1'b1, 1'b0);
    ex_start();
    do_start();
    ex_byte(8'hA3, 1'b1, 1'b0);
    send_byte(8'hA3, 1'b0, 1'b0);
    ex_byte(8'h42, 1'b0, 1'b0);
    send_byte(8'h42, 1'b0, 1'b1);
    ex_stop(1'b0);
    do_stop();
    wc(8);
    chk("rw_after_t3", bus.rw, 32'h1);
    chk("cnt_after_t3", bus.frame_cnt, 32'h3);

    // STOP after 5 data bits: frame error, count held
    ex_start();
    do_start();
    ex_byte(8'hA0, 1'b1, 1'b0);
    send_byte(8'hA0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    ex_stop(1'b1);
    do_stop();
    wc(8);
    chk("cnt_after_err", bus.frame_cnt, 32'h3);

    // Reset mid-byte, released with both lines low
    ex_start();
    do_start();
    ex_byte(8'hA0, 1'b1, 1'b0);
    send_byte(8'hA0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    wc(8);
    chk("queue_before_reset", exp_q.size(), 32'h0);
    reset = 1'b1;
    wc(1);
    chk("midreset_flags",
        {bus.start_det, bus.rstart_det, bus.stop_det, bus.byte_valid,
         bus.frame_err, bus.busy, bus.rw, bus.byte_is_addr, bus.byte_ack},
        32'h0);
    chk("midreset_byte_data", bus.byte_data, 32'h0);
    chk("midreset_frame_cnt", bus.frame_cnt, 32'h0);
    m_busy = 1'b0;
    m_rw   = 1'b0;
    m_cnt  = '0;
    wc(2);
    reset = 1'b0;
    wc(10);
    bus.sda = 1'b1; wc(6);
    bus.scl = 1'b1; wc(10);
    chk("busy_after_release", bus.busy, 32'h0);

    // Minimal frames up to the counter limit, then wrap
    repeat ((1 << CW) - 1) begin
      ex_start();
      bus.sda = 1'b0; wc(4);
      ex_stop(1'b0);
      bus.sda = 1'b1; wc(4);
    end
    wc(8);
    chk("cnt_at_max", bus.frame_cnt, (1 << CW) - 1);
    ex_start();
    bus.sda = 1'b0; wc(4);
    ex_stop(1'b0);
    bus.sda = 1'b1; wc(10);
    chk("cnt_wrapped", bus.frame_cnt, 32'h0);

`ifdef I2C_GLITCH_FILTER_EN
    bus.sda = 1'b0; wc(2);
    bus.sda = 1'b1; wc(12);
    chk("glitch2_cnt", bus.frame_cnt, 32'h0);
    n0 = cyc + 1;
    ex_start();
    bus.sda = 1'b0; wc(3);
    ex_stop(1'b0);
    bus.sda = 1'b1; wc(14);
    chk("glitch3_latency", last_start_cyc - n0, 32'd5);
    chk("glitch3_cnt", bus.frame_cnt, 32'h1);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++)
      wc(1);
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
